// File: rtl/heater_pkg.sv
// Shared constants and FSM state type for the heater thermostat.
package heater_pkg;

    localparam int ADC_W = 12;
    localparam int SUM_W = 16;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_HEAT  = 2'd1;
    localparam logic [1:0] ST_COAST = 2'd2;
    localparam logic [1:0] ST_FAULT = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        HEAT  = ST_HEAT,
        COAST = ST_COAST,
        FAULT = ST_FAULT
    } state_e;

endpackage

// File: rtl/heater_thermostat_adc_avg.sv
// Block averager: accumulates 2^AVG_LOG2 qualified samples, then publishes the
// mean on avg_o and pulses new_avg_o for one cycle.
module adc_avg
    import heater_pkg::*;
#(
    parameter int unsigned AVG_LOG2 = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [ADC_W-1:0] sample_i,
    input  logic             sample_valid_i,
    output logic [ADC_W-1:0] avg_o,
    output logic             new_avg_o
);

    logic [SUM_W-1:0]    sum_q, sum_d, sum_next;
    logic [AVG_LOG2-1:0] cnt_q, cnt_d;
    logic [ADC_W-1:0]    avg_q, avg_d;
    logic                new_q, new_d;

    assign sum_next = sum_q + SUM_W'(sample_i);

    always_comb begin
        sum_d = sum_q;
        cnt_d = cnt_q;
        avg_d = avg_q;
        new_d = 1'b0;
        if (sample_valid_i) begin
            if (&cnt_q) begin
                // Last sample of the block folds straight into the result.
                avg_d = ADC_W'(sum_next >> AVG_LOG2);
                sum_d = '0;
                cnt_d = '0;
                new_d = 1'b1;
            end else begin
                sum_d = sum_next;
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sum_q <= '0;
            cnt_q <= '0;
            avg_q <= '0;
            new_q <= 1'b0;
        end else begin
            sum_q <= sum_d;
            cnt_q <= cnt_d;
            avg_q <= avg_d;
            new_q <= new_d;
        end
    end

    assign avg_o     = avg_q;
    assign new_avg_o = new_q;

endmodule

// File: rtl/heater_thermostat.sv
// Bang-bang heater controller with sensor-range and runaway protection.
// Define HEATER_PWM_LIMIT_EN to cap the HEAT drive with an 8-bit PWM duty limit.
module heater_thermostat
    import heater_pkg::*;
#(
    parameter int unsigned AVG_LOG2       = 2,
    parameter int unsigned HYST           = 10,
    parameter int unsigned SENSOR_HI      = 3250,
    parameter int unsigned SENSOR_LO      = 20,
    parameter int unsigned RUNAWAY_CYCLES = 1000000000,
    parameter int unsigned MIN_DROP       = 5
`ifdef HEATER_PWM_LIMIT_EN
    ,
    parameter int unsigned MAX_DUTY       = 255
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [ADC_W-1:0] target_adc,
    input  logic [ADC_W-1:0] adc_value,
    input  logic             adc_valid,
    output logic             heater_on,
    output logic             at_temp,
    output logic             fault,
    output logic [ADC_W-1:0] avg_adc
);

    localparam int CW = ADC_W + 1;
    localparam int TW = $clog2(RUNAWAY_CYCLES + 1);

    logic             new_avg;
    state_e           state_q, state_d;
    logic [TW-1:0]    timer_q, timer_d, elapsed;
    logic [ADC_W-1:0] ref_q, ref_d;
    logic             at_temp_q, at_temp_d;

    logic [CW-1:0] avg_w, tgt_w, ref_w;
    logic          run_on, too_cold, too_warm, sensor_bad, progress;

    adc_avg #(
        .AVG_LOG2(AVG_LOG2)
    ) u_avg (
        .clk           (clk),
        .reset         (reset),
        .sample_i      (adc_value),
        .sample_valid_i(adc_valid),
        .avg_o         (avg_adc),
        .new_avg_o     (new_avg)
    );

    // One spare bit keeps target+HYST and avg+MIN_DROP from wrapping.
    assign avg_w      = {1'b0, avg_adc};
    assign tgt_w      = {1'b0, target_adc};
    assign ref_w      = {1'b0, ref_q};
    assign run_on     = enable && (target_adc != '0);
    assign too_cold   = avg_w > (tgt_w + CW'(HYST));
    assign too_warm   = (avg_w + CW'(HYST)) < tgt_w;
    assign sensor_bad = new_avg && ((avg_w >= CW'(SENSOR_HI)) || (avg_w <= CW'(SENSOR_LO)));
    assign progress   = new_avg && ((avg_w + CW'(MIN_DROP)) <= ref_w);
    assign elapsed    = progress ? '0 : timer_q + TW'(1);

    always_comb begin
        state_d   = state_q;
        timer_d   = '0;
        ref_d     = ref_q;
        at_temp_d = at_temp_q;

        case (state_q)
            IDLE: begin
                if (new_avg && run_on) state_d = too_cold ? HEAT : COAST;
            end
            HEAT: begin
                if (sensor_bad)                              state_d = FAULT;
                else if (elapsed >= TW'(RUNAWAY_CYCLES))     state_d = FAULT;
                else if (!run_on)                            state_d = IDLE;
                else if (new_avg && too_warm)                state_d = COAST;
            end
            COAST: begin
                if (sensor_bad)                              state_d = FAULT;
                else if (!run_on)                            state_d = IDLE;
                else if (new_avg && too_cold)                state_d = HEAT;
            end
            default: state_d = FAULT;
        endcase

        // Runaway reference is the average seen on HEAT entry or last real drop.
        if (state_d == HEAT) begin
            if (state_q != HEAT) begin
                timer_d = '0;
                ref_d   = avg_adc;
            end else begin
                timer_d = elapsed;
                if (progress) ref_d = avg_adc;
            end
        end

        if ((state_d == IDLE) || (state_d == FAULT)) at_temp_d = 1'b0;
        else if (new_avg)                            at_temp_d = !too_cold && !too_warm;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            ref_q     <= '0;
            at_temp_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            ref_q     <= ref_d;
            at_temp_q <= at_temp_d;
        end
    end

`ifdef HEATER_PWM_LIMIT_EN
    logic [7:0] pwm_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) pwm_cnt_q <= '0;
        else       pwm_cnt_q <= pwm_cnt_q + 8'd1;
    end

    assign heater_on = (state_q == HEAT) && ({1'b0, pwm_cnt_q} < 9'(MAX_DUTY));
`else
    assign heater_on = (state_q == HEAT);
`endif

    assign at_temp = at_temp_q;
    assign fault   = (state_q == FAULT);

endmodule

// File: tb/tb_heater_thermostat.sv
// Scoreboard bench: stimulus pushes per-cycle expectations from a behavioural
// model, a negedge monitor pops and compares them against the DUT.
module tb_heater_thermostat;

    localparam int N   = 4;
    localparam int HY  = 10;
    localparam int SHI = 3250;
    localparam int SLO = 20;
    localparam int RUN = 100;
    localparam int MD  = 5;

    localparam int M_IDLE  = 0;
    localparam int M_HEAT  = 1;
    localparam int M_COAST = 2;
    localparam int M_FAULT = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic [11:0] target_adc = '0;
    logic [11:0] adc_value = '0;
    logic        adc_valid = 1'b0;
    logic        heater_on, at_temp, fault;
    logic [11:0] avg_adc;

    always #5 clk = ~clk;

    heater_thermostat #(
        .AVG_LOG2      (2),
        .HYST          (HY),
        .SENSOR_HI     (SHI),
        .SENSOR_LO     (SLO),
        .RUNAWAY_CYCLES(RUN),
        .MIN_DROP      (MD)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .target_adc(target_adc),
        .adc_value (adc_value),
        .adc_valid (adc_valid),
        .heater_on (heater_on),
        .at_temp   (at_temp),
        .fault     (fault),
        .avg_adc   (avg_adc)
    );

    typedef struct {
        int avg;
        bit heat;
        bit at;
        bit flt;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    // Behavioural model state
    int samples[$];
    int m_avg = 0;
    bit m_new = 0;
    int m_state = M_IDLE;
    int m_timer = 0;
    int m_ref = 0;
    bit m_at = 0;

    bit       cur_en = 0;
    int       cur_tgt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic model_step(input bit r, input bit en, input int tgt, input bit v, input int val);
        int ns, nt, nref, elapsed, nav, s;
        bit nnew, nat, on, bad, prog;
        if (r) begin
            samples.delete();
            m_avg = 0; m_new = 0; m_state = M_IDLE;
            m_timer = 0; m_ref = 0; m_at = 0;
        end else begin
            on      = en && (tgt != 0);
            ns      = m_state;
            nt      = 0;
            nref    = m_ref;
            nat     = m_at;
            bad     = m_new && (m_avg >= SHI || m_avg <= SLO);
            prog    = m_new && (m_avg + MD <= m_ref);
            elapsed = prog ? 0 : m_timer + 1;
            case (m_state)
                M_IDLE:  if (m_new && on) ns = (m_avg > tgt + HY) ? M_HEAT : M_COAST;
                M_HEAT: begin
                    if (bad || elapsed >= RUN)          ns = M_FAULT;
                    else if (!on)                       ns = M_IDLE;
                    else if (m_new && m_avg + HY < tgt) ns = M_COAST;
                end
                M_COAST: begin
                    if (bad)                            ns = M_FAULT;
                    else if (!on)                       ns = M_IDLE;
                    else if (m_new && m_avg > tgt + HY) ns = M_HEAT;
                end
                default: ns = M_FAULT;
            endcase
            if (ns == M_HEAT) begin
                if (m_state != M_HEAT) begin
                    nt = 0; nref = m_avg;
                end else begin
                    nt = elapsed;
                    if (prog) nref = m_avg;
                end
            end
            if (ns == M_IDLE || ns == M_FAULT) nat = 0;
            else if (m_new) nat = (m_avg <= tgt + HY) && (m_avg >= tgt - HY);
            nav  = m_avg;
            nnew = 0;
            if (v) begin
                samples.push_back(val);
                if (samples.size() == N) begin
                    s = 0;
                    foreach (samples[k]) s += samples[k];
                    nav  = s / N;
                    nnew = 1;
                    samples.delete();
                end
            end
            m_state = ns; m_timer = nt; m_ref = nref; m_at = nat;
            m_avg = nav; m_new = nnew;
        end
        sb.push_back('{m_avg, m_state == M_HEAT, m_at, m_state == M_FAULT});
    endtask

    task automatic tick(input bit r, input bit v, input int val);
        reset      = r;
        enable     = cur_en;
        target_adc = 12'(cur_tgt);
        adc_valid  = v;
        adc_value  = 12'(val);
        model_step(r, cur_en, cur_tgt, v, val);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, int'($urandom_range(0, 4095)));
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            cur_en  = 1'($urandom_range(0, 1));
            cur_tgt = int'($urandom_range(0, 4095));
            tick(1'b1, 1'($urandom_range(0, 1)), int'($urandom_range(0, 4095)));
        end
        cur_en  = 1;
        cur_tgt = 2000;
    endtask

    task automatic batch(input int val, input int maxgap, input bit jitter);
        int x;
        for (int i = 0; i < N; i++) begin
            idle(int'($urandom_range(0, maxgap)));
            x = val + (jitter ? int'($urandom_range(0, 3)) : 0);
            if (x > 4095) x = 4095;
            tick(1'b0, 1'b1, x);
        end
        idle(2);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check("avg_adc", 32'(avg_adc), 32'(e.avg));
            check("heater_on", 32'(heater_on), 32'(e.heat));
            check("at_temp", 32'(at_temp), 32'(e.at));
            check("fault", 32'(fault), 32'(e.flt));
        end
    end

    initial begin : stim
        int offs[6];
        int val;
        offs = '{-11, -10, -9, 9, 10, 11};

        // Reset with random inputs
        do_reset(3);
        // Heat-up from IDLE, then coast and settle into the band
        batch(2500, 0, 0);
        batch(1985, 2, 0);
        batch(1995, 2, 0);
        // Runaway: flat reading while heating
        do_reset(2);
        batch(2500, 0, 0);
        for (int i = 0; i < 140; i++) tick(1'b0, (i % 3) == 0, 2500);
        // Steady progress keeps the runaway timer from expiring
        do_reset(2);
        for (int k = 0; k < 15; k++) batch(2500 - MD * k, 3, 0);
        // Sensor open and short while coasting
        do_reset(2);
        batch(1995, 1, 0);
        batch(3300, 1, 0);
        idle(5);
        do_reset(2);
        batch(1995, 1, 0);
        batch(10, 1, 0);
        // Zero target keeps IDLE; a real target then starts heating
        do_reset(2);
        cur_tgt = 0;
        batch(3000, 1, 0);
        cur_tgt = 2000;
        batch(3000, 1, 0);
        cur_en = 0;
        idle(3);

        // Randomised phase around the hysteresis and sensor boundaries
        for (int it = 0; it < 80; it++) begin
            if ($urandom_range(0, 3) == 0) do_reset(1);
            cur_en = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 2) == 0)
                cur_tgt = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(200, 3000));
            case ($urandom_range(0, 9))
                0:       val = SHI;
                1:       val = SHI - 1;
                2:       val = SLO;
                3:       val = SLO + 1;
                4, 5, 6: val = cur_tgt + offs[$urandom_range(0, 5)];
                default: val = cur_tgt + int'($urandom_range(0, 120)) - 60;
            endcase
            if (val < 0) val = 0;
            batch(val, 3, 1'($urandom_range(0, 1)));
        end

        #10;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
